// File: rtl/mprc_refill_unit_if.sv
// Refill unit bus bundle: request, Grant, data/meta array writes, Finish.
// slave is the refill unit side, master is the MSHR/memory/array side.
interface mprc_refill_unit_if #(
    parameter int BEATS  = 4,
    parameter int DATA_W = 128,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 20,
    parameter int WAYS   = 4
);
    localparam int BW = $clog2(BEATS);
    localparam int AW = IDX_W + TAG_W;
    localparam int WA = IDX_W + BW + 4;

    logic              req_ready;
    logic              req_valid;
    logic [AW-1:0]     req_bits_addr_block;
    logic [WAYS-1:0]   req_bits_way_en;
    logic [1:0]        req_bits_client_xact_id;
    logic [1:0]        req_bits_coh;

    logic              grant_ready;
    logic              grant_valid;
    logic [BW-1:0]     grant_bits_addr_beat;
    logic [1:0]        grant_bits_client_xact_id;
    logic [3:0]        grant_bits_manager_xact_id;
    logic [DATA_W-1:0] grant_bits_data;

    logic              data_write_ready;
    logic              data_write_valid;
    logic [WAYS-1:0]   data_write_bits_way_en;
    logic [WA-1:0]     data_write_bits_addr;
    logic [DATA_W-1:0] data_write_bits_data;

    logic              meta_write_ready;
    logic              meta_write_valid;
    logic [IDX_W-1:0]  meta_write_bits_idx;
    logic [WAYS-1:0]   meta_write_bits_way_en;
    logic [TAG_W-1:0]  meta_write_bits_tag;
    logic [1:0]        meta_write_bits_coh;

    logic              finish_ready;
    logic              finish_valid;
    logic [3:0]        finish_bits_manager_xact_id;

    logic              done;
    logic [1:0]        done_xact_id;

    modport slave (
        output req_ready,
        input  req_valid, req_bits_addr_block, req_bits_way_en,
        input  req_bits_client_xact_id, req_bits_coh,
        output grant_ready,
        input  grant_valid, grant_bits_addr_beat,
        input  grant_bits_client_xact_id, grant_bits_manager_xact_id,
        input  grant_bits_data,
        input  data_write_ready,
        output data_write_valid, data_write_bits_way_en,
        output data_write_bits_addr, data_write_bits_data,
        input  meta_write_ready,
        output meta_write_valid, meta_write_bits_idx,
        output meta_write_bits_way_en, meta_write_bits_tag,
        output meta_write_bits_coh,
        input  finish_ready,
        output finish_valid, finish_bits_manager_xact_id,
        output done, done_xact_id
    );

    modport master (
        input  req_ready,
        output req_valid, req_bits_addr_block, req_bits_way_en,
        output req_bits_client_xact_id, req_bits_coh,
        input  grant_ready,
        output grant_valid, grant_bits_addr_beat,
        output grant_bits_client_xact_id, grant_bits_manager_xact_id,
        output grant_bits_data,
        output data_write_ready,
        input  data_write_valid, data_write_bits_way_en,
        input  data_write_bits_addr, data_write_bits_data,
        output meta_write_ready,
        input  meta_write_valid, meta_write_bits_idx,
        input  meta_write_bits_way_en, meta_write_bits_tag,
        input  meta_write_bits_coh,
        output finish_ready,
        input  finish_valid, finish_bits_manager_xact_id,
        input  done, done_xact_id
    );
endinterface

// File: rtl/mprc_refill_unit.sv
// Cache refill unit: Grant beats -> one-entry buffer -> data array,
// then metadata write and Finish back to the manager.
module mprc_refill_unit #(
    parameter int BEATS  = 4,
    parameter int DATA_W = 128,
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 20,
    parameter int WAYS   = 4
) (
    input  logic clk,
    input  logic reset_n,
    mprc_refill_unit_if.slave io
);
    localparam int BW = $clog2(BEATS);
    localparam int CW = BW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_META,
        S_FINISH
    } state_e;

    state_e              state_q;
    logic [CW-1:0]       beat_cnt_q;
    logic [CW-1:0]       wr_cnt_q;
    logic                buf_v_q;
    logic [DATA_W-1:0]   buf_data_q;
    logic [BW-1:0]       buf_beat_q;
    logic [IDX_W+TAG_W-1:0] addr_q;
    logic [WAYS-1:0]     way_q;
    logic [1:0]          cid_q;
    logic [1:0]          coh_q;
    logic [3:0]          mgr_q;

    logic req_fire;
    logic gnt_fire;
    logic wr_fire;
    logic last_wr;

    assign req_fire = io.req_ready & io.req_valid;
    assign gnt_fire = io.grant_ready & io.grant_valid;
    assign wr_fire  = buf_v_q & io.data_write_ready;
    assign last_wr  = wr_fire & (wr_cnt_q == CW'(BEATS - 1));

    // Buffer can take a beat when empty or draining this very cycle.
    assign io.grant_ready = (state_q == S_REFILL)
                          & (beat_cnt_q != CW'(BEATS))
                          & (~buf_v_q | wr_fire)
                          & ~last_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            buf_v_q    <= 1'b0;
            beat_cnt_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (io.req_valid) begin
                        beat_cnt_q <= '0;
                        wr_cnt_q   <= '0;
                        state_q    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (gnt_fire)
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    if (wr_fire && wr_cnt_q != CW'(BEATS))
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                    if (gnt_fire)
                        buf_v_q <= 1'b1;
                    else if (wr_fire)
                        buf_v_q <= 1'b0;
                    if (last_wr)
                        state_q <= S_META;
                end
                S_META: begin
                    if (io.meta_write_ready)
                        state_q <= S_FINISH;
                end
                S_FINISH: begin
                    if (io.finish_ready)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Request and beat payloads carry no reset; they are gated by state.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            addr_q <= io.req_bits_addr_block;
            way_q  <= io.req_bits_way_en;
            cid_q  <= io.req_bits_client_xact_id;
            coh_q  <= io.req_bits_coh;
        end
        if (gnt_fire) begin
            buf_data_q <= io.grant_bits_data;
            buf_beat_q <= io.grant_bits_addr_beat;
            mgr_q      <= io.grant_bits_manager_xact_id;
        end
    end

    assign io.req_ready = (state_q == S_IDLE);

    assign io.data_write_valid       = buf_v_q;
    assign io.data_write_bits_way_en = way_q;
    assign io.data_write_bits_addr   = {addr_q[IDX_W-1:0], buf_beat_q, 4'h0};
    assign io.data_write_bits_data   = buf_data_q;

    assign io.meta_write_valid       = (state_q == S_META);
    assign io.meta_write_bits_idx    = addr_q[IDX_W-1:0];
    assign io.meta_write_bits_tag    = addr_q[IDX_W +: TAG_W];
    assign io.meta_write_bits_way_en = way_q;
    assign io.meta_write_bits_coh    = coh_q;

    assign io.finish_valid                = (state_q == S_FINISH);
    assign io.finish_bits_manager_xact_id = mgr_q;

    assign io.done         = io.finish_valid & io.finish_ready;
    assign io.done_xact_id = cid_q;
endmodule

// File: tb/tb_mprc_refill_unit.sv
// Directed bench for mprc_refill_unit: table of refills plus
// backpressure, stall, back-to-back and async reset sequences.
module tb_mprc_refill_unit;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mprc_refill_unit_if io ();

    mprc_refill_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io)
    );

    typedef struct packed {
        logic [25:0]     addr;
        logic [3:0]      way;
        logic [1:0]      cid;
        logic [1:0]      gcid;
        logic [1:0]      coh;
        logic [3:0]      mgr;
        logic [3:0][1:0] ord;
        logic [5:0]      idx;
        logic [19:0]     tag;
    } vec_t;

    vec_t vt [4];

    int nvec = 0;
    int nmis = 0;

    logic [11:0]  wr_addr_q [$];
    logic [127:0] wr_data_q [$];
    logic [3:0]   wr_way_q  [$];
    logic [5:0]   m_idx_q   [$];
    logic [19:0]  m_tag_q   [$];
    logic [1:0]   m_coh_q   [$];
    logic [3:0]   m_way_q   [$];
    int           m_wc_q    [$];
    logic [3:0]   f_mgr_q   [$];
    logic [1:0]   d_cid_q   [$];

    always @(negedge clk) begin
        if (io.data_write_valid && io.data_write_ready) begin
            wr_addr_q.push_back(io.data_write_bits_addr);
            wr_data_q.push_back(io.data_write_bits_data);
            wr_way_q.push_back(io.data_write_bits_way_en);
        end
        if (io.meta_write_valid && io.meta_write_ready) begin
            m_idx_q.push_back(io.meta_write_bits_idx);
            m_tag_q.push_back(io.meta_write_bits_tag);
            m_coh_q.push_back(io.meta_write_bits_coh);
            m_way_q.push_back(io.meta_write_bits_way_en);
            m_wc_q.push_back(wr_addr_q.size());
        end
        if (io.finish_valid && io.finish_ready)
            f_mgr_q.push_back(io.finish_bits_manager_xact_id);
        if (io.done)
            d_cid_q.push_back(io.done_xact_id);
    end

    function automatic void chk(string name, logic [127:0] act,
                                logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [127:0] mk_data(int vi, int b);
        return {32'(vi), 32'(b), 32'hA5A5_0000 + 32'(b),
                32'h1357_9BDF ^ 32'(vi * 4 + b)};
    endfunction

    task automatic issue_req(input int vi);
        int n = 0;
        bit acc = 0;
        io.req_bits_addr_block     = vt[vi].addr;
        io.req_bits_way_en         = vt[vi].way;
        io.req_bits_client_xact_id = vt[vi].cid;
        io.req_bits_coh            = vt[vi].coh;
        io.req_valid               = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = io.req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        io.req_valid = 1'b0;
        chk("req_accept", 128'(acc), 128'd1);
    endtask

    task automatic send_beat(input logic [1:0] b, input logic [127:0] d,
                             input logic [1:0] c, input logic [3:0] m);
        int n = 0;
        bit fired = 0;
        io.grant_valid                = 1'b1;
        io.grant_bits_addr_beat       = b;
        io.grant_bits_data            = d;
        io.grant_bits_client_xact_id  = c;
        io.grant_bits_manager_xact_id = m;
        while (!fired && n < 50) begin
            @(negedge clk);
            fired = io.grant_ready;
            @(posedge clk);
            #1;
            n++;
        end
        io.grant_valid = 1'b0;
        if (!fired)
            chk("beat_accept_timeout", 128'(fired), 128'd1);
    endtask

    task automatic send_all(input int vi);
        for (int k = 0; k < 4; k++)
            send_beat(vt[vi].ord[k], mk_data(vi, int'(vt[vi].ord[k])),
                      vt[vi].gcid, vt[vi].mgr);
    endtask

    task automatic check_refill(input int vi, input int wb, input int mb,
                                input int fb, input int db);
        int n = 0;
        logic [1:0]  b;
        logic [11:0] ea;
        while (d_cid_q.size() <= db && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 128'(d_cid_q.size() > db), 128'd1);
        chk("wr_count", 128'(wr_addr_q.size() - wb), 128'd4);
        for (int k = 0; k < 4; k++) begin
            if (wb + k < wr_addr_q.size()) begin
                b  = vt[vi].ord[k];
                ea = {vt[vi].idx, b, 4'h0};
                chk("wr_addr", 128'(wr_addr_q[wb+k]), 128'(ea));
                chk("wr_data", wr_data_q[wb+k], mk_data(vi, int'(b)));
                chk("wr_way", 128'(wr_way_q[wb+k]), 128'(vt[vi].way));
            end
        end
        chk("meta_count", 128'(m_idx_q.size() - mb), 128'd1);
        if (mb < m_idx_q.size()) begin
            chk("meta_idx", 128'(m_idx_q[mb]), 128'(vt[vi].idx));
            chk("meta_tag", 128'(m_tag_q[mb]), 128'(vt[vi].tag));
            chk("meta_coh", 128'(m_coh_q[mb]), 128'(vt[vi].coh));
            chk("meta_way", 128'(m_way_q[mb]), 128'(vt[vi].way));
            chk("meta_after_4_wr", 128'(m_wc_q[mb] - wb), 128'd4);
        end
        chk("fin_count", 128'(f_mgr_q.size() - fb), 128'd1);
        if (fb < f_mgr_q.size())
            chk("fin_mgr", 128'(f_mgr_q[fb]), 128'(vt[vi].mgr));
        chk("done_count", 128'(d_cid_q.size() - db), 128'd1);
        if (db < d_cid_q.size())
            chk("done_cid", 128'(d_cid_q[db]), 128'(vt[vi].cid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, mb, fb, db;
        int n;
        bit acc, prev_done;

        vt[0] = '{26'h00000A5, 4'b0100, 2'd1, 2'd1, 2'd2, 4'h3,
                  {2'd3, 2'd2, 2'd1, 2'd0}, 6'h25, 20'h00002};
        vt[1] = '{26'h3FFFFFF, 4'b1000, 2'd3, 2'd3, 2'd3, 4'hF,
                  {2'd0, 2'd1, 2'd2, 2'd3}, 6'h3F, 20'hFFFFF};
        vt[2] = '{26'h0000000, 4'b0001, 2'd0, 2'd0, 2'd1, 4'h0,
                  {2'd1, 2'd3, 2'd0, 2'd2}, 6'h00, 20'h00000};
        vt[3] = '{26'h1234567, 4'b0010, 2'd2, 2'd1, 2'd0, 4'hA,
                  {2'd2, 2'd0, 2'd3, 2'd1}, 6'h27, 20'h48D15};

        reset_n                       = 1'b0;
        io.req_valid                  = 1'b0;
        io.req_bits_addr_block        = '0;
        io.req_bits_way_en            = '0;
        io.req_bits_client_xact_id    = '0;
        io.req_bits_coh               = '0;
        io.grant_valid                = 1'b0;
        io.grant_bits_addr_beat       = '0;
        io.grant_bits_client_xact_id  = '0;
        io.grant_bits_manager_xact_id = '0;
        io.grant_bits_data            = '0;
        io.data_write_ready           = 1'b1;
        io.meta_write_ready           = 1'b1;
        io.finish_ready               = 1'b1;

        #3;
        chk("rst_req_ready", 128'(io.req_ready), 128'd1);
        chk("rst_grant_ready", 128'(io.grant_ready), 128'd0);
        chk("rst_dw_valid", 128'(io.data_write_valid), 128'd0);
        chk("rst_mw_valid", 128'(io.meta_write_valid), 128'd0);
        chk("rst_fin_valid", 128'(io.finish_valid), 128'd0);
        chk("rst_done", 128'(io.done), 128'd0);
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            wb = wr_addr_q.size(); mb = m_idx_q.size();
            fb = f_mgr_q.size();   db = d_cid_q.size();
            issue_req(i);
            send_all(i);
            check_refill(i, wb, mb, fb, db);
            @(posedge clk);
            #1;
        end

        // data backpressure during beat 1
        wb = wr_addr_q.size(); mb = m_idx_q.size();
        fb = f_mgr_q.size();   db = d_cid_q.size();
        issue_req(0);
        fork
            send_all(0);
            begin
                repeat (2) @(posedge clk);
                #1 io.data_write_ready = 1'b0;
                @(negedge clk);
                chk("bp_grant_ready", 128'(io.grant_ready), 128'd0);
                chk("bp_dw_valid", 128'(io.data_write_valid), 128'd1);
                chk("bp_dw_addr", 128'(io.data_write_bits_addr),
                    128'h950);
                repeat (3) @(posedge clk);
                #1 io.data_write_ready = 1'b1;
            end
        join
        check_refill(0, wb, mb, fb, db);
        @(posedge clk);
        #1;

        // meta then finish stall
        io.meta_write_ready = 1'b0;
        io.finish_ready     = 1'b0;
        wb = wr_addr_q.size(); mb = m_idx_q.size();
        fb = f_mgr_q.size();   db = d_cid_q.size();
        issue_req(1);
        fork
            send_all(1);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!io.meta_write_valid && n < 100);
                for (int i = 0; i < 5; i++) begin
                    chk("ms_valid", 128'(io.meta_write_valid), 128'd1);
                    chk("ms_tag", 128'(io.meta_write_bits_tag),
                        128'(vt[1].tag));
                    chk("ms_req_ready", 128'(io.req_ready), 128'd0);
                    @(negedge clk);
                end
                io.meta_write_ready = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!io.finish_valid && n < 100);
                for (int i = 0; i < 4; i++) begin
                    chk("fs_valid", 128'(io.finish_valid), 128'd1);
                    chk("fs_mgr", 128'(io.finish_bits_manager_xact_id),
                        128'(vt[1].mgr));
                    chk("fs_req_ready", 128'(io.req_ready), 128'd0);
                    chk("fs_done", 128'(io.done), 128'd0);
                    @(negedge clk);
                end
                io.finish_ready = 1'b1;
                #1;
                chk("fs_done_pulse", 128'(io.done), 128'd1);
                chk("fs_req_ready_fire", 128'(io.req_ready), 128'd0);
                @(negedge clk);
                chk("fs_req_ready_after", 128'(io.req_ready), 128'd1);
                chk("fs_done_once", 128'(io.done), 128'd0);
            end
        join
        check_refill(1, wb, mb, fb, db);
        @(posedge clk);
        #1;

        // back-to-back requests
        wb = wr_addr_q.size(); mb = m_idx_q.size();
        fb = f_mgr_q.size();   db = d_cid_q.size();
        issue_req(2);
        send_all(2);
        io.req_bits_addr_block     = vt[3].addr;
        io.req_bits_way_en         = vt[3].way;
        io.req_bits_client_xact_id = vt[3].cid;
        io.req_bits_coh            = vt[3].coh;
        io.req_valid               = 1'b1;
        acc = 0; prev_done = 0; n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (io.req_ready) begin
                acc = 1;
                chk("b2b_after_done", 128'(prev_done), 128'd1);
            end else begin
                prev_done = io.done;
            end
            n++;
        end
        chk("b2b_accept", 128'(acc), 128'd1);
        @(posedge clk);
        #1 io.req_valid = 1'b0;
        check_refill(2, wb, mb, fb, db);
        wb = wr_addr_q.size(); mb = m_idx_q.size();
        fb = f_mgr_q.size();   db = d_cid_q.size();
        send_all(3);
        check_refill(3, wb, mb, fb, db);
        @(posedge clk);
        #1;

        // async reset after two beats
        issue_req(0);
        send_beat(2'd0, mk_data(0, 0), vt[0].gcid, vt[0].mgr);
        send_beat(2'd1, mk_data(0, 1), vt[0].gcid, vt[0].mgr);
        chk("ar_pre_dw_valid", 128'(io.data_write_valid), 128'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_dw_valid", 128'(io.data_write_valid), 128'd0);
        chk("ar_grant_ready", 128'(io.grant_ready), 128'd0);
        chk("ar_mw_valid", 128'(io.meta_write_valid), 128'd0);
        chk("ar_fin_valid", 128'(io.finish_valid), 128'd0);
        chk("ar_done", 128'(io.done), 128'd0);
        chk("ar_req_ready", 128'(io.req_ready), 128'd1);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        wb = wr_addr_q.size(); mb = m_idx_q.size();
        fb = f_mgr_q.size();   db = d_cid_q.size();
        issue_req(1);
        send_all(1);
        check_refill(1, wb, mb, fb, db);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
